// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Requester and memory-side signal bundle for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int CTRL_W = 4,
    parameter int WORD_W = 32
);
    logic [N_REQ-1:0]          req;
    logic [N_REQ*CTRL_W-1:0]   req_ctrl;
    logic [N_REQ*WORD_W-1:0]   req_addr;
    logic [N_REQ*WORD_W-1:0]   req_din;
    logic [N_REQ-1:0]          lock;
    logic [N_REQ-1:0]          ready;
    logic [WORD_W-1:0]         rdata;
    logic [$clog2(N_REQ)-1:0]  gnt_id;
    logic                      busy;
    logic [CTRL_W-1:0]         mem_ctrl;
    logic [WORD_W-1:0]         mem_addr;
    logic [WORD_W-1:0]         mem_din;
    logic [WORD_W-1:0]         mem_dout;

    modport slave (
        input  req, req_ctrl, req_addr, req_din, lock, mem_dout,
        output ready, rdata, gnt_id, busy, mem_ctrl, mem_addr, mem_din
    );

    modport master (
        output req, req_ctrl, req_addr, req_din, lock, mem_dout,
        input  ready, rdata, gnt_id, busy, mem_ctrl, mem_addr, mem_din
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one fixed-latency memory port;
//               optional grant lock for atomic RMW when MEM_ARB_LOCK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int N_REQ       = 2,
    parameter int MEM_LATENCY = 1,
    parameter int CTRL_W      = 4,
    parameter int WORD_W      = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int                  c_ID_W  = $clog2(N_REQ);
    localparam int                  c_CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(MEM_LATENCY);
    localparam logic [c_ID_W:0]     c_N     = (c_ID_W + 1)'(N_REQ);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_ID_W-1:0]    r_rr, w_rr_nxt;
    logic [c_ID_W-1:0]    r_gnt, w_gnt_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_relock, w_relock_nxt;
    logic [CTRL_W-1:0]    r_mem_ctrl, w_mem_ctrl_nxt;
    logic [WORD_W-1:0]    r_mem_addr, w_mem_addr_nxt;
    logic [WORD_W-1:0]    r_mem_din, w_mem_din_nxt;

    logic [2*N_REQ-1:0]   w_req_dbl;
    logic [N_REQ-1:0]     w_req_rot;
    logic [c_ID_W-1:0]    w_off;
    logic [c_ID_W:0]      w_sum;
    logic [c_ID_W-1:0]    w_rr_winner;
    logic [c_ID_W-1:0]    w_winner;
    logic                 w_any;
    logic                 w_hold;
    logic                 w_lock_sel;
    logic                 w_done;
    logic [CTRL_W-1:0]    w_sel_ctrl;
    logic [WORD_W-1:0]    w_sel_addr;
    logic [WORD_W-1:0]    w_sel_din;

`ifdef MEM_ARB_LOCK_EN
    assign w_lock_sel = bus.lock[r_gnt];
`else
    logic w_lock_unused;
    assign w_lock_sel    = 1'b0;
    assign w_lock_unused = ^bus.lock;
`endif

    // Rotate so bit k of w_req_rot is requester (rr+1+k) mod N_REQ.
    assign w_req_dbl = {bus.req, bus.req} >> ({1'b0, r_rr} + (c_ID_W + 1)'(1));
    assign w_req_rot = w_req_dbl[N_REQ-1:0];
    assign w_any     = |bus.req;

    always_comb begin
        w_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_req_rot[i]) w_off = c_ID_W'(i);
        end
    end

    assign w_sum       = {1'b0, r_rr} + {1'b0, w_off} + (c_ID_W + 1)'(1);
    assign w_rr_winner = (w_sum >= c_N) ? c_ID_W'(w_sum - c_N) : c_ID_W'(w_sum);
    assign w_hold      = r_relock & bus.req[r_gnt];
    assign w_winner    = w_hold ? r_gnt : w_rr_winner;

    always_comb begin
        w_sel_ctrl = '0;
        w_sel_addr = '0;
        w_sel_din  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_winner == c_ID_W'(i)) begin
                w_sel_ctrl = bus.req_ctrl[i*CTRL_W +: CTRL_W];
                w_sel_addr = bus.req_addr[i*WORD_W +: WORD_W];
                w_sel_din  = bus.req_din[i*WORD_W +: WORD_W];
            end
        end
    end

    assign w_done = (r_state == S_ACCESS) && (r_cnt == c_LAST);

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_nxt       = r_rr;
        w_gnt_nxt      = r_gnt;
        w_cnt_nxt      = r_cnt;
        w_busy_nxt     = r_busy;
        w_relock_nxt   = r_relock;
        w_mem_ctrl_nxt = r_mem_ctrl;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_din_nxt  = r_mem_din;
        case (r_state)
            S_IDLE: begin
                w_relock_nxt   = 1'b0;
                w_mem_ctrl_nxt = '0;
                w_mem_addr_nxt = '0;
                w_mem_din_nxt  = '0;
                if (w_any) begin
                    w_state_nxt    = S_ACCESS;
                    w_gnt_nxt      = w_winner;
                    w_cnt_nxt      = '0;
                    w_busy_nxt     = 1'b1;
                    w_mem_ctrl_nxt = w_sel_ctrl;
                    w_mem_addr_nxt = w_sel_addr;
                    w_mem_din_nxt  = w_sel_din;
                    // A locked re-grant does not advance the fairness pointer.
                    if (!w_hold) w_rr_nxt = w_winner;
                end
            end
            S_ACCESS: begin
                if (w_done) begin
                    w_state_nxt    = S_IDLE;
                    w_busy_nxt     = 1'b0;
                    w_mem_ctrl_nxt = '0;
                    w_mem_addr_nxt = '0;
                    w_mem_din_nxt  = '0;
                    w_relock_nxt   = w_lock_sel & bus.req[r_gnt];
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr       <= c_ID_W'(N_REQ - 1);
            r_gnt      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_relock   <= 1'b0;
            r_mem_ctrl <= '0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr       <= w_rr_nxt;
            r_gnt      <= w_gnt_nxt;
            r_cnt      <= w_cnt_nxt;
            r_busy     <= w_busy_nxt;
            r_relock   <= w_relock_nxt;
            r_mem_ctrl <= w_mem_ctrl_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_din  <= w_mem_din_nxt;
        end
    end

    assign bus.ready    = w_done ? (N_REQ'(1) << r_gnt) : '0;
    assign bus.rdata    = w_done ? bus.mem_dout : '0;
    assign bus.gnt_id   = r_gnt;
    assign bus.busy     = r_busy;
    assign bus.mem_ctrl = r_mem_ctrl;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_din  = r_mem_din;
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter against a cycle-number
//               transaction model (latency 1) plus a latency-3 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    localparam int N    = 2;
    localparam int CW   = 4;
    localparam int WW   = 32;
    localparam int IDW  = 1;
    localparam int LAT  = 1;
    localparam logic [WW-1:0] c_KEY  = 32'h5A5A_1234;
    localparam logic [WW-1:0] c_KEY3 = 32'h0F0F_7777;
`ifdef MEM_ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.N_REQ(N), .CTRL_W(CW), .WORD_W(WW)) bus ();
    mem_arbiter_if #(.N_REQ(N), .CTRL_W(CW), .WORD_W(WW)) bus3 ();

    mem_arbiter #(.N_REQ(N), .MEM_LATENCY(LAT), .CTRL_W(CW), .WORD_W(WW)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    mem_arbiter #(.N_REQ(N), .MEM_LATENCY(3), .CTRL_W(CW), .WORD_W(WW)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3));

    logic          ovr_en = 1'b0;
    logic [WW-1:0] ovr_val = '0;
    assign bus.mem_dout  = ovr_en ? ovr_val : (bus.mem_addr ^ c_KEY);
    assign bus3.mem_dout = bus3.mem_addr ^ c_KEY3;

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus presented for the next cycle
    logic [N-1:0]  s_req, s_lock;
    logic [CW-1:0] s_ctrl [N];
    logic [WW-1:0] s_addr [N];
    logic [WW-1:0] s_din  [N];

    // reference model: a transaction issued in cycle c occupies c+1..c+1+LAT
    int            cyc, m_rr, m_gnt, m_issue, m_ready_at;
    bit            m_relock;
    logic [CW-1:0] m_ctrl;
    logic [WW-1:0] m_addr, m_din;

    logic [N-1:0]   e_ready;
    logic [WW-1:0]  e_rdata, e_addr, e_din;
    logic [CW-1:0]  e_ctrl;
    logic [IDW-1:0] e_gnt;
    logic           e_busy;

    task automatic model_reset();
        cyc = 0; m_rr = N - 1; m_gnt = 0; m_issue = -10; m_ready_at = -1;
        m_relock = 1'b0; m_ctrl = '0; m_addr = '0; m_din = '0;
    endtask

    task automatic tick();
        int w;
        bit found;
        @(posedge clk);
        #1;
        bus.req  = s_req;
        bus.lock = s_lock;
        for (int i = 0; i < N; i++) begin
            bus.req_ctrl[i*CW +: CW] = s_ctrl[i];
            bus.req_addr[i*WW +: WW] = s_addr[i];
            bus.req_din[i*WW +: WW]  = s_din[i];
        end
        @(negedge clk);
        e_busy  = (cyc > m_issue) && (cyc <= m_ready_at);
        e_ready = (cyc == m_ready_at) ? (N'(1) << m_gnt) : '0;
        e_rdata = (cyc == m_ready_at) ? (ovr_en ? ovr_val : (m_addr ^ c_KEY)) : '0;
        e_ctrl  = e_busy ? m_ctrl : '0;
        e_addr  = e_busy ? m_addr : '0;
        e_din   = e_busy ? m_din : '0;
        e_gnt   = IDW'(m_gnt);
        if (cyc == m_ready_at) begin
            m_relock = LOCK_ON && s_lock[m_gnt] && s_req[m_gnt];
        end else if (cyc > m_ready_at) begin
            if (s_req != '0) begin
                found = 1'b0;
                w = 0;
                if (m_relock && s_req[m_gnt]) begin
                    w = m_gnt;
                end else begin
                    for (int k = 1; k <= N; k++) begin
                        int idx;
                        idx = (m_rr + k) % N;
                        if (!found && s_req[idx]) begin
                            w = idx;
                            found = 1'b1;
                        end
                    end
                    m_rr = w;
                end
                m_gnt = w; m_issue = cyc; m_ready_at = cyc + 1 + LAT;
                m_ctrl = s_ctrl[w]; m_addr = s_addr[w]; m_din = s_din[w];
            end
            m_relock = 1'b0;
        end
        cyc++;
    endtask

    task automatic clear_stim();
        s_req = '0; s_lock = '0;
        for (int i = 0; i < N; i++) begin
            s_ctrl[i] = '0; s_addr[i] = '0; s_din[i] = '0;
        end
    endtask

    task automatic do_reset();
        clear_stim();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drain();
        s_req = '0; s_lock = '0;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_stim();
        bus.req = '0; bus.lock = '0; bus.req_ctrl = '0; bus.req_addr = '0; bus.req_din = '0;
        bus3.req = '0; bus3.lock = '0; bus3.req_ctrl = '0; bus3.req_addr = '0; bus3.req_din = '0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.ready !== '0 || bus.mem_ctrl !== '0 || bus.gnt_id !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b ready=%b ctrl=%h gnt=%0d, expected all zero",
                     bus.busy, bus.ready, bus.mem_ctrl, bus.gnt_id);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        s_req = 2'b01; s_ctrl[0] = 4'h3; s_addr[0] = 32'h0000_0040;
        tick();
        tick();
        n_checks++;
        if (bus.busy !== e_busy) begin
            n_fail++;
            $display("FAIL reset_pre_busy: got %b expected %b", bus.busy, e_busy);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_ctrl !== '0 || bus.ready !== '0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: ctrl=%h ready=%b busy=%b expected 0/00/0",
                     bus.mem_ctrl, bus.ready, bus.busy);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        s_req = 2'b11; s_ctrl[0] = 4'h1; s_ctrl[1] = 4'h2;
        tick();
        tick();
        n_checks++;
        if (bus.gnt_id !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_grant: gnt=%0d busy=%b expected 0/1", bus.gnt_id, bus.busy);
        end
        drain();
    endtask

    task automatic test_single_read();
        ovr_en = 1'b1; ovr_val = 32'hDEAD_BEEF;
        s_req = 2'b01; s_ctrl[0] = 4'h1; s_addr[0] = 32'h0000_0100; s_din[0] = '0;
        tick();
        tick();
        n_checks++;
        if (bus.mem_addr !== 32'h100 || bus.ready !== 2'b00 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_access: addr=%h ready=%b busy=%b expected 100/00/1",
                     bus.mem_addr, bus.ready, bus.busy);
        end
        tick();
        n_checks++;
        if (bus.ready !== 2'b01 || bus.rdata !== 32'hDEAD_BEEF || bus.mem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL single_ready: ready=%b rdata=%h addr=%h expected 01/deadbeef/100",
                     bus.ready, bus.rdata, bus.mem_addr);
        end
        s_req = '0;
        tick();
        n_checks++;
        if (bus.mem_ctrl !== '0 || bus.ready !== '0 || bus.rdata !== '0) begin
            n_fail++;
            $display("FAIL single_idle: ctrl=%h ready=%b rdata=%h expected zeros",
                     bus.mem_ctrl, bus.ready, bus.rdata);
        end
        ovr_en = 1'b0;
    endtask

    task automatic test_contention();
        int nr = 0;
        do_reset();
        s_req = 2'b11; s_ctrl[0] = 4'h5; s_ctrl[1] = 4'h9;
        s_addr[0] = 32'h1000; s_addr[1] = 32'h2000;
        for (int c = 0; c < 30 && nr < 4; c++) begin
            tick();
            n_checks++;
            if (bus.ready !== e_ready || bus.mem_ctrl !== e_ctrl) begin
                n_fail++;
                $display("FAIL contention_cycle: ready=%b ctrl=%h expected %b/%h",
                         bus.ready, bus.mem_ctrl, e_ready, e_ctrl);
            end
            if (bus.ready !== '0) begin
                n_checks++;
                if (bus.ready !== ((nr % 2 == 0) ? 2'b01 : 2'b10)) begin
                    n_fail++;
                    $display("FAIL contention_order: grant %0d ready=%b expected %b",
                             nr, bus.ready, (nr % 2 == 0) ? 2'b01 : 2'b10);
                end
                nr++;
            end
        end
        n_checks++;
        if (nr != 4) begin
            n_fail++;
            $display("FAIL contention_timeout: %0d completions expected 4", nr);
        end
        drain();
    endtask

    task automatic test_latency();
        logic          exp_busy;
        logic [N-1:0]  exp_rdy;
        logic [WW-1:0] exp_addr, exp_rd;
        tick();
        bus3.req_ctrl = '0; bus3.req_addr = '0;
        bus3.req_ctrl[0 +: CW] = 4'h2;
        bus3.req_addr[0 +: WW] = 32'h0000_0ABC;
        bus3.req = 2'b01;
        for (int n = 1; n <= 6; n++) begin
            tick();
            exp_busy = (n <= 4);
            exp_rdy  = (n == 4) ? 2'b01 : 2'b00;
            exp_addr = (n <= 4) ? 32'h0000_0ABC : '0;
            exp_rd   = (n == 4) ? (32'h0000_0ABC ^ c_KEY3) : '0;
            n_checks++;
            if (bus3.ready !== exp_rdy || bus3.mem_addr !== exp_addr ||
                bus3.busy !== exp_busy || bus3.rdata !== exp_rd) begin
                n_fail++;
                $display("FAIL latency3_cycle%0d: ready=%b addr=%h busy=%b rdata=%h expected %b/%h/%b/%h",
                         n, bus3.ready, bus3.mem_addr, bus3.busy, bus3.rdata,
                         exp_rdy, exp_addr, exp_busy, exp_rd);
            end
            if (n == 4) bus3.req = '0;
        end
    endtask

    task automatic test_drop_req();
        s_req = 2'b01; s_ctrl[0] = 4'h7; s_addr[0] = 32'h0000_0300;
        tick();
        s_req = 2'b00;
        tick();
        tick();
        n_checks++;
        if (bus.ready !== 2'b01 || bus.ready !== e_ready) begin
            n_fail++;
            $display("FAIL drop_ready: ready=%b expected 01", bus.ready);
        end
        for (int n = 0; n < 3; n++) begin
            tick();
            n_checks++;
            if (bus.busy !== 1'b0 || bus.ready !== 2'b00) begin
                n_fail++;
                $display("FAIL drop_no_reissue: busy=%b ready=%b expected 0/00", bus.busy, bus.ready);
            end
        end
    endtask

    task automatic test_lock();
        logic [N-1:0] tab [4];
        int nr = 0;
        if (LOCK_ON) begin
            tab[0] = 2'b01; tab[1] = 2'b01; tab[2] = 2'b01; tab[3] = 2'b10;
        end else begin
            tab[0] = 2'b01; tab[1] = 2'b10; tab[2] = 2'b01; tab[3] = 2'b10;
        end
        do_reset();
        s_req = 2'b11; s_lock = 2'b01; s_ctrl[0] = 4'hA; s_ctrl[1] = 4'hB;
        s_addr[0] = 32'h0000_0500; s_addr[1] = 32'h0000_0600;
        for (int c = 0; c < 40 && nr < 4; c++) begin
            tick();
            n_checks++;
            if (bus.ready !== e_ready) begin
                n_fail++;
                $display("FAIL lock_cycle: ready=%b expected %b", bus.ready, e_ready);
            end
            if (bus.ready !== '0) begin
                n_checks++;
                if (bus.ready !== tab[nr]) begin
                    n_fail++;
                    $display("FAIL lock_order: grant %0d ready=%b expected %b", nr, bus.ready, tab[nr]);
                end
                nr++;
                if (nr == 2) s_lock = 2'b00;
            end
        end
        n_checks++;
        if (nr != 4) begin
            n_fail++;
            $display("FAIL lock_timeout: %0d completions expected 4", nr);
        end
        drain();
    endtask

    task automatic test_random();
        bit pending [N];
        bit cool    [N];
        do_reset();
        for (int i = 0; i < N; i++) begin
            pending[i] = 1'b0; cool[i] = 1'b0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && !cool[i] && $urandom_range(0, 2) == 0) begin
                    pending[i] = 1'b1;
                    s_req[i]   = 1'b1;
                    s_ctrl[i]  = CW'($urandom_range(1, 15));
                    s_addr[i]  = $urandom;
                    s_din[i]   = $urandom;
                end
                cool[i] = 1'b0;
            end
            s_lock = N'($urandom);
            tick();
            n_checks++;
            if (bus.ready !== e_ready) begin
                n_fail++;
                $display("FAIL rand_ready c%0d: got %b expected %b", c, bus.ready, e_ready);
            end
            n_checks++;
            if (bus.rdata !== e_rdata) begin
                n_fail++;
                $display("FAIL rand_rdata c%0d: got %h expected %h", c, bus.rdata, e_rdata);
            end
            n_checks++;
            if (bus.busy !== e_busy || bus.gnt_id !== e_gnt) begin
                n_fail++;
                $display("FAIL rand_busy_gnt c%0d: got %b/%0d expected %b/%0d",
                         c, bus.busy, bus.gnt_id, e_busy, e_gnt);
            end
            n_checks++;
            if (bus.mem_ctrl !== e_ctrl || bus.mem_addr !== e_addr || bus.mem_din !== e_din) begin
                n_fail++;
                $display("FAIL rand_mem c%0d: got %h/%h/%h expected %h/%h/%h", c,
                         bus.mem_ctrl, bus.mem_addr, bus.mem_din, e_ctrl, e_addr, e_din);
            end
            for (int i = 0; i < N; i++) begin
                if (e_ready[i]) begin
                    pending[i] = 1'b0; s_req[i] = 1'b0; cool[i] = 1'b1;
                end
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_latency();
        test_drop_req();
        test_lock();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
